// File: rtl/eq_pkg.sv
// Shared types and fixed-point helpers for the multi-band EQ biquad engine.
package eq_pkg;
    typedef enum logic [2:0] {B0 = 3'd0, B1, B2, A1, A2} coef_idx_e;
    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} biquad_state_e;

    localparam int Q_DATA_W    = 16;
    localparam int Q_FRAC_BITS = 14;
    localparam int NUM_TAPS    = 5;

    typedef struct packed {
        logic signed [31:0] val;
        logic               clip;
    } sat_res_t;

    // Round half-up then clamp to a dw-bit signed range; acc must fit in 64 bits and dw <= 32.
    function automatic sat_res_t sat_round(input logic signed [63:0] acc, input int frac, input int dw);
        logic signed [63:0] r, hi, lo;
        sat_res_t res;
        r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        res.clip = (r > hi) || (r < lo);
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        res.val = 32'(r);
        return res;
    endfunction
endpackage

// File: rtl/mac_accum_unit.sv
// Signed multiply-accumulator: load or add/subtract one full-width product per enabled cycle.
module mac_accum_unit #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic              i_load,
    input  logic              i_sub,
    input  logic [DATA_W-1:0] i_x,
    input  logic [COEF_W-1:0] i_c,
    output logic [ACC_W-1:0]  o_acc
);
    logic signed [DATA_W+COEF_W-1:0] w_prod;
    logic signed [ACC_W-1:0]         w_term;
    logic signed [ACC_W-1:0]         w_base;
    logic signed [ACC_W-1:0]         r_acc;

    assign w_prod = $signed(i_x) * $signed(i_c);
    assign w_term = {{(ACC_W-DATA_W-COEF_W){w_prod[DATA_W+COEF_W-1]}}, w_prod};
    assign w_base = i_load ? '0 : r_acc;
    assign o_acc  = r_acc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_acc <= '0;
        else if (i_ce) r_acc <= i_sub ? (w_base - w_term) : (w_base + w_term);
    end
endmodule

// File: rtl/biquad_mac_engine.sv
// Time-multiplexed DF-I biquad bank: one shared MAC computes NUM_CH bands from each input sample.
module biquad_mac_engine import eq_pkg::*; #(
    parameter  int DATA_W    = Q_DATA_W,
    parameter  int COEF_W    = 16,
    parameter  int FRAC_BITS = Q_FRAC_BITS,
    parameter  int ACC_W     = 40,
    parameter  int NUM_CH    = 3,
    localparam int AW        = $clog2(NUM_TAPS*NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_state_clr,
    input  logic                     i_sample_valid,
    output logic                     o_sample_ready,
    input  logic [DATA_W-1:0]        i_sample_in,
    input  logic                     i_coef_we,
    input  logic [AW-1:0]            i_coef_addr,
    input  logic [COEF_W-1:0]        i_coef_wdata,
    output logic                     o_coef_err,
    output logic [NUM_CH*DATA_W-1:0] o_band_out,
    output logic                     o_out_valid,
    output logic                     o_busy,
    output logic                     o_sat_flag
);
    localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [AW-1:0]   NCOEF   = AW'(NUM_TAPS*NUM_CH);

    biquad_state_e     r_state;
    logic [CH_W-1:0]   r_ch;
    logic [2:0]        r_tap;
    logic [DATA_W-1:0] r_x0, r_x1, r_x2;
    logic [COEF_W-1:0] r_coef [NUM_TAPS*NUM_CH];
    logic [DATA_W-1:0] r_y1   [NUM_CH];
    logic [DATA_W-1:0] r_y2   [NUM_CH];
    logic [DATA_W-1:0] r_band [NUM_CH];
    logic              r_out_valid, r_coef_err, r_sat;

    logic [AW-1:0]     w_cidx;
    logic [DATA_W-1:0] w_x;
    logic [COEF_W-1:0] w_c;
    logic              w_sub, w_mac_ce, w_coef_ok;
    logic [ACC_W-1:0]  w_acc;
    sat_res_t          w_sat;
    logic [DATA_W-1:0] w_rsat;

    assign o_sample_ready = (r_state == IDLE) && i_state_clr;
    assign o_busy         = (r_state != IDLE);
    assign o_out_valid    = r_out_valid;
    assign o_coef_err     = r_coef_err;
    assign o_sat_flag     = r_sat;

    // Coefficients only change while no sample is in flight, so a band never mixes old and new taps.
    assign w_coef_ok = (r_state == IDLE) && i_state_clr && (i_coef_addr < NCOEF);
    assign w_cidx    = AW'({r_ch, 2'b00}) + AW'(r_ch) + AW'(r_tap);
    assign w_mac_ce  = (r_state == MAC) && i_state_clr;

    always_comb begin
        w_x   = '0;
        w_sub = 1'b0;
        w_c   = r_coef[w_cidx];
        case (coef_idx_e'(r_tap))
            B0:      w_x = r_x0;
            B1:      w_x = r_x1;
            B2:      w_x = r_x2;
            A1:      begin w_x = r_y1[r_ch]; w_sub = 1'b1; end
            A2:      begin w_x = r_y2[r_ch]; w_sub = 1'b1; end
            default: w_x = '0;
        endcase
    end

    mac_accum_unit #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
        .i_clk  (i_clk),
        .i_rst_n(i_reset),
        .i_ce   (w_mac_ce),
        .i_load (r_tap == 3'd0),
        .i_sub  (w_sub),
        .i_x    (w_x),
        .i_c    (w_c),
        .o_acc  (w_acc)
    );

    assign w_sat  = sat_round(64'($signed(w_acc)), FRAC_BITS, DATA_W);
    assign w_rsat = DATA_W'(w_sat.val);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign o_band_out[g*DATA_W +: DATA_W] = r_band[g];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_ch        <= '0;
            r_tap       <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_out_valid <= 1'b0;
            r_coef_err  <= 1'b0;
            r_sat       <= 1'b0;
            for (int i = 0; i < NUM_TAPS*NUM_CH; i++) r_coef[i] <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_y1[i]   <= '0;
                r_y2[i]   <= '0;
                r_band[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_coef_err  <= i_coef_we && !w_coef_ok;
            if (i_coef_we && w_coef_ok) r_coef[i_coef_addr] <= i_coef_wdata;

            if (!i_state_clr) begin
                r_state <= IDLE;
                r_ch    <= '0;
                r_tap   <= '0;
                r_x1    <= '0;
                r_x2    <= '0;
                r_sat   <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    r_y1[i]   <= '0;
                    r_y2[i]   <= '0;
                    r_band[i] <= '0;
                end
            end else begin
                case (r_state)
                    IDLE: if (i_sample_valid) begin
                        r_x0    <= i_sample_in;
                        r_ch    <= '0;
                        r_tap   <= '0;
                        r_state <= MAC;
                    end
                    MAC: begin
                        if (r_tap == 3'd4) r_state <= WB;
                        else               r_tap   <= r_tap + 3'd1;
                    end
                    WB: begin
                        r_band[r_ch] <= w_rsat;
                        r_y2[r_ch]   <= r_y1[r_ch];
                        r_y1[r_ch]   <= w_rsat;
                        if (w_sat.clip) r_sat <= 1'b1;
                        r_tap <= '0;
                        if (r_ch == LAST_CH) begin
                            r_x2    <= r_x1;
                            r_x1    <= r_x0;
                            r_state <= DONE;
                        end else begin
                            r_ch    <= r_ch + 1'b1;
                            r_state <= MAC;
                        end
                    end
                    DONE: begin
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_biquad_mac_engine.sv
// Directed bench for biquad_mac_engine: expected band vectors are queued at accept and checked on out_valid.
module tb_biquad_mac_engine;
    localparam int DW  = 16;
    localparam int NCH = 3;
    localparam int AW  = 4;

    logic              clk = 1'b0, rst_n = 1'b0, st_clr = 1'b1, s_valid = 1'b0, we = 1'b0;
    logic [DW-1:0]     s_in = '0;
    logic [AW-1:0]     addr = '0;
    logic [15:0]       wdata = '0;
    logic              ready, cerr, ov, busy, sat;
    logic [NCH*DW-1:0] band;

    int checks = 0, errors = 0, cyc = 0, t0 = 0;
    logic [NCH*DW-1:0] sb[$];

    biquad_mac_engine dut (
        .i_clk(clk), .i_reset(rst_n), .i_state_clr(st_clr),
        .i_sample_valid(s_valid), .o_sample_ready(ready), .i_sample_in(s_in),
        .i_coef_we(we), .i_coef_addr(addr), .i_coef_wdata(wdata), .o_coef_err(cerr),
        .o_band_out(band), .o_out_valid(ov), .o_busy(busy), .o_sat_flag(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ov === 1'b1) begin
            if (sb.size() == 0) chk("spurious_out_valid", 64'(ov), 64'd0);
            else begin
                logic [NCH*DW-1:0] e;
                e = sb.pop_front();
                chk("band_out", 64'(band), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    task automatic wr(input int ch, input int k, input logic [15:0] d);
        we = 1'b1; addr = AW'(ch*5 + k); wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic accept(input logic [15:0] s, input bit push, input logic [NCH*DW-1:0] exp);
        for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
        s_valid = 1'b1; s_in = s;
        if (push) sb.push_back(exp);
        tick();
        s_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_out(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (ov === 1'b1) break;
            tick();
        end
        chk({tag, "_latency"}, 64'(cyc - t0), 64'd19);
        tick();
    endtask

    initial begin
        int seen;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_band", 64'(band), 64'd0);
        chk("rst_ov",   64'(ov),   64'd0);
        chk("rst_sat",  64'(sat),  64'd0);
        chk("rst_cerr", 64'(cerr), 64'd0);
        rst_n = 1'b1; tick();
        chk("rst_ready", 64'(ready), 64'd1);

        // pass-through on band 0
        wr(0, 0, 16'h4000);
        accept(16'h2000, 1, 48'h0000_0000_2000); wait_out("pass");

        // one-sample delay on band 1
        hard_reset(); wr(1, 1, 16'h4000);
        accept(16'h4000, 1, 48'h0000_0000_0000); wait_out("delay0");
        accept(16'h0000, 1, 48'h0000_4000_0000); wait_out("delay1");

        // first-order feedback on band 2
        hard_reset(); wr(2, 0, 16'h4000); wr(2, 3, 16'hE000);
        accept(16'h4000, 1, 48'h4000_0000_0000); wait_out("fb0");
        accept(16'h0000, 1, 48'h2000_0000_0000); wait_out("fb1");
        accept(16'h0000, 1, 48'h1000_0000_0000); wait_out("fb2");

        // saturation both ways, then rounding
        hard_reset(); wr(0, 0, 16'h7FFF);
        accept(16'h7FFF, 1, 48'h0000_0000_7FFF); wait_out("sat_pos");
        chk("sat_set", 64'(sat), 64'd1);
        accept(16'h8000, 1, 48'h0000_0000_8000); wait_out("sat_neg");
        chk("sat_sticky", 64'(sat), 64'd1);
        wr(0, 0, 16'h0001);
        accept(16'h2000, 1, 48'h0000_0000_0001); wait_out("round_half");
        accept(16'h1FFF, 1, 48'h0000_0000_0000); wait_out("round_below");
        chk("sat_still", 64'(sat), 64'd1);

        // write and accept in the same IDLE cycle: new coefficient applies
        hard_reset();
        we = 1'b1; addr = 4'd0; wdata = 16'h4000;
        s_valid = 1'b1; s_in = 16'h3000; sb.push_back(48'h0000_0000_3000);
        tick();
        we = 1'b0; s_valid = 1'b0; t0 = cyc;
        wait_out("wr_accept");

        // write while busy is dropped; old coefficient still used
        accept(16'h2000, 1, 48'h0000_0000_2000);
        tick(); tick();
        we = 1'b1; addr = 4'd0; wdata = 16'h2000;
        tick();
        we = 1'b0;
        chk("busy_cerr", 64'(cerr), 64'd1);
        tick();
        chk("cerr_pulse", 64'(cerr), 64'd0);
        wait_out("busy_wr");

        // out-of-range address
        we = 1'b1; addr = 4'd15; wdata = 16'h1234;
        tick();
        we = 1'b0;
        chk("badaddr_cerr", 64'(cerr), 64'd1);
        tick();
        chk("badaddr_pulse", 64'(cerr), 64'd0);

        // build up history and a sat flag, then abort a run with state_clr
        wr(1, 0, 16'h7FFF);
        accept(16'h7FFF, 1, 48'h0000_7FFF_7FFF); wait_out("pre_abort");
        chk("pre_abort_sat", 64'(sat), 64'd1);
        accept(16'h2000, 0, '0);
        repeat (6) tick();
        st_clr = 1'b0; s_valid = 1'b1; s_in = 16'h1111;
        #1;
        chk("clr_ready", 64'(ready), 64'd0);
        tick();
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_band", 64'(band), 64'd0);
        chk("clr_sat",  64'(sat),  64'd0);
        tick();
        chk("clr_hold_busy", 64'(busy), 64'd0);
        s_valid = 1'b0; st_clr = 1'b1;
        seen = 0;
        repeat (25) begin tick(); if (ov === 1'b1) seen++; end
        chk("abort_no_ov", 64'(seen), 64'd0);

        // next sample sees cleared history (x1 would otherwise add 0x7FFF*0.5)
        wr(0, 1, 16'h4000);
        accept(16'h1000, 1, 48'h0000_2000_1000); wait_out("post_clr");
        chk("post_clr_sat", 64'(sat), 64'd0);

        // async reset mid-MAC
        accept(16'h2000, 0, '0);
        tick(); tick(); tick();
        chk("midmac_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_band", 64'(band), 64'd0);
        chk("arst_ov",   64'(ov),   64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_ready", 64'(ready), 64'd1);
        accept(16'h2000, 1, 48'h0000_0000_0000); wait_out("arst_coefs");
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/biquad_mac_engine.md
Name: biquad_mac_engine

Overview:
- Time-multiplexed Direct-Form-I biquad engine for the real-time multi-band EQ.
- One shared signed multiply-accumulator serves NUM_CH parallel bands from the same input sample.
- Holds the coefficient bank and per-band history, and adds rounding, saturation and a sample handshake.
- Sits between the audio sample source and the band mixer.

Parameters:
- DATA_W, 16: sample width, signed Q2.14 at default.
- COEF_W, 16: coefficient width, signed.
- FRAC_BITS, 14: fractional bits shared by samples and coefficients.
- ACC_W, 40: accumulator width; must be at least DATA_W+COEF_W+3.
- NUM_CH, 3: number of bands (biquads).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- state_clr, in, 1: synchronous active-low history clear and abort.
- sample_valid, in, 1: input sample offered.
- sample_ready, out, 1: engine can accept a sample.
- sample_in, in, DATA_W: signed input sample.
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, $clog2(5*NUM_CH): coefficient address = ch*5 + k, with k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_wdata, in, COEF_W: signed coefficient.
- coef_err, out, 1: one-cycle pulse when a write is dropped.
- band_out, out, NUM_CH*DATA_W: packed band outputs; band 0 in the LSBs.
- out_valid, out, 1: one-cycle pulse when band_out updates.
- busy, out, 1: high whenever the FSM is not in IDLE.
- sat_flag, out, 1: sticky saturation indicator.

Behaviour:
- Reset (reset=0):
  - FSM goes to IDLE.
  - All coefficients, x1, x2, every y1/y2, band_out, out_valid, coef_err, sat_flag and the accumulator clear to 0.
  - sample_ready = (state==IDLE) && state_clr.
- FSM states: IDLE, MAC, WB, DONE.
- IDLE -> MAC on sample_valid && sample_ready. sample_in is latched as x0, and the channel counter and tap counter clear.
- MAC: one product per cycle, tap k = 0..4.
  - Operand pairs per tap: (b0,x0), (b1,x1), (b2,x2), (a1,y1[ch]), (a2,y2[ch]).
  - Tap 0 loads the accumulator; taps 1-4 accumulate.
  - b-terms are added; a-terms are subtracted: y = b0x0 + b1x1 + b2x2 - a1y1 - a2y2.
  - Products are full DATA_W+COEF_W signed, sign-extended to ACC_W.
- MAC -> WB after tap 4.
- WB:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; if clipping occurs, set sat_flag.
  - band_out[ch] <= r_sat, y2[ch] <= y1[ch], y1[ch] <= r_sat.
  - If ch < NUM_CH-1: increment ch and return to MAC.
  - Otherwise: x2 <= x1, x1 <= x0, go to DONE.
- DONE: out_valid=1 for exactly one cycle, then IDLE.
- Latency: out_valid is high in the cycle starting 6*NUM_CH+1 edges after the accepting edge (19 at default NUM_CH=3).
- Throughput: one sample per 6*NUM_CH+2 cycles.
- band_out holds its value between updates.
- Coefficient writes:
  - Applied only in IDLE with state_clr=1.
  - A write in any other state is dropped and coef_err pulses on the following cycle.
  - An address >= 5*NUM_CH is dropped and coef_err pulses.
  - A write and a sample accept in the same IDLE cycle: the write lands first, and the new coefficient is used for that sample.
- state_clr=0, in any state:
  - Next state is IDLE.
  - x1, x2, all y1/y2, band_out and sat_flag clear; coefficients are kept.
  - No out_valid for an aborted sample.
  - sample_ready is 0 while state_clr=0, so clear wins over a simultaneous sample_valid.
- Async reset asserted mid-operation: immediate return to the reset state; no partial band_out update.

Decomposition:
- Shared package eq_pkg:
  - coef_idx_e enum (B0, B1, B2, A1, A2).
  - biquad_state_e enum (IDLE, MAC, WB, DONE).
  - Q-format constants.
  - sat_round function (acc, FRAC_BITS, DATA_W -> saturated value + clip bit).
- Sub-module mac_accum_unit:
  - Parameterised DATA_W/COEF_W/ACC_W.
  - Inputs: load, ce, sub.
  - Output: registered acc.
  - Generalises the existing 16x16->32 accumulate MAC.
- Coefficients and histories are register arrays inside biquad_mac_engine.

Test Plan:
- Pass-through: ch0 b0=0x4000, all other coefs 0; sample 0x2000 -> out_valid 19 cycles after accept, band0=0x2000, band1=band2=0x0000.
- Delay tap: ch1 b1=0x4000; samples 0x4000 then 0x0000 -> band1 = 0x0000, then 0x4000.
- Feedback: ch2 b0=0x4000, a1=0xE000 (-0.5); impulse 0x4000, 0, 0 -> band2 = 0x4000, 0x2000, 0x1000.
- Rounding and saturation:
  - ch0 b0=0x7FFF, sample 0x7FFF -> band0=0x7FFF, sat_flag=1 and stays 1.
  - Sample 0x8000 -> band0=0x8000 (clamped).
  - b0=0x0001, sample 0x2000 -> band0=0x0001 (rounded half-up).
- Control:
  - coef_we during busy -> coef_err pulse; output uses the old coefficient.
  - state_clr=0 at cycle 7 of a run -> no out_valid; sample_ready=0 while low.
  - Next sample sees zero history; sat_flag=0.
- Reset: reset=0 mid-MAC -> busy=0, band_out=0, coefficients 0; sample_ready=1 after release.
